// File: rtl/mdu_ctrl_if.sv
// Request/result bundle between the EXE stage and the multiply/divide unit.
// The master side (the requester) drives the request and flush; the slave side (the unit) drives busy, done and the results.
interface mdu_ctrl_if;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req_valid, req_op, op1, op2, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  req_valid, req_op, op1, op2, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply, restoring divide,
// one operand bit per cycle on operand magnitudes, with the sign fixed up on completion.
module mdu_ctrl #(
  parameter bit FAST_ZERO = 1'b1
) (
  input logic        clk,
  input logic        reset,
  mdu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] mag1, mag2;
  logic        sign1, sign2;
  logic        is_div;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic        done_q, dbz_q;
  logic [31:0] hi_q, lo_q;

  logic        accept;
  logic        in_signed, in_div, in_fast;
  logic [31:0] in_mag1, in_mag2;
  logic [31:0] fast_hi, fast_lo;
  logic        fast_dbz;

  logic [32:0] mul_sum;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] acc_nx;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;
  logic        res_dbz;
  logic        last_iter;

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

  assign accept    = (state == IDLE) && bus.req_valid && !bus.flush;
  assign last_iter = (cnt == 5'd31);

  // Request decode: magnitudes, and the zero shortcut results produced at acceptance
  always_comb begin
    in_signed = ~bus.req_op[0];
    in_div    = bus.req_op[1];
    in_mag1   = (in_signed && bus.op1[31]) ? (32'd0 - bus.op1) : bus.op1;
    in_mag2   = (in_signed && bus.op2[31]) ? (32'd0 - bus.op2) : bus.op2;
    in_fast   = 1'b0;
    if (FAST_ZERO) begin
      if (in_div) in_fast = (bus.op2 == '0);
      else        in_fast = (bus.op1 == '0) || (bus.op2 == '0);
    end
    fast_hi  = '0;
    fast_lo  = '0;
    fast_dbz = 1'b0;
    if (in_div) begin
      fast_hi  = bus.op1;
      fast_lo  = '1;
      fast_dbz = 1'b1;
    end
  end

  // One iteration of the datapath
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag1} : 33'd0);
    div_ge   = (acc[63:31] >= {1'b0, mag2});
    div_diff = acc[63:31] - {1'b0, mag2};
    if (is_div) begin
      if (div_ge) acc_nx = {div_diff[31:0], acc[30:0], 1'b1};
      else        acc_nx = {acc[62:0], 1'b0};
    end else begin
      acc_nx = {mul_sum, acc[31:1]};
    end
  end

  // Final sign fix-up applied to the value produced by the last iteration
  always_comb begin
    prod    = (sign1 ^ sign2) ? (64'd0 - acc_nx) : acc_nx;
    res_hi  = prod[63:32];
    res_lo  = prod[31:0];
    res_dbz = 1'b0;
    if (is_div) begin
      if (mag2 == '0) begin
        res_hi  = sign1 ? (32'd0 - mag1) : mag1;
        res_lo  = '1;
        res_dbz = 1'b1;
      end else begin
        res_lo = (sign1 ^ sign2) ? (32'd0 - acc_nx[31:0]) : acc_nx[31:0];
        res_hi = sign1 ? (32'd0 - acc_nx[63:32]) : acc_nx[63:32];
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = in_fast ? DONE : CALC;
      CALC: if (last_iter) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      mag1   <= '0;
      mag2   <= '0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      is_div <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
    end else begin
      done_q <= (state_nx == DONE);
      if (accept) begin
        mag1   <= in_mag1;
        mag2   <= in_mag2;
        sign1  <= in_signed & bus.op1[31];
        sign2  <= in_signed & bus.op2[31];
        is_div <= in_div;
        cnt    <= '0;
        acc    <= in_div ? {32'd0, in_mag1} : {32'd0, in_mag2};
        if (in_fast) begin
          hi_q  <= fast_hi;
          lo_q  <= fast_lo;
          dbz_q <= fast_dbz;
        end
      end else if (state == CALC && !bus.flush) begin
        acc <= acc_nx;
        if (last_iter) begin
          hi_q  <= res_hi;
          lo_q  <= res_lo;
          dbz_q <= res_dbz;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: one instance with the zero shortcut, one without, compared against an arithmetic model.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;

  logic        o_busy, o_done, o_dbz;
  logic [31:0] o_hi, o_lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_ctrl_if ifa ();
  mdu_ctrl_if ifb ();

  assign ifa.req_valid = req_valid & ~sel;
  assign ifa.flush     = flush & ~sel;
  assign ifa.req_op    = req_op;
  assign ifa.op1       = op1;
  assign ifa.op2       = op2;
  assign ifb.req_valid = req_valid & sel;
  assign ifb.flush     = flush & sel;
  assign ifb.req_op    = req_op;
  assign ifb.op1       = op1;
  assign ifb.op2       = op2;

  assign o_busy = sel ? ifb.busy        : ifa.busy;
  assign o_done = sel ? ifb.done        : ifa.done;
  assign o_dbz  = sel ? ifb.div_by_zero : ifa.div_by_zero;
  assign o_hi   = sel ? ifb.hi          : ifa.hi;
  assign o_lo   = sel ? ifb.lo          : ifa.lo;

  mdu_ctrl #(.FAST_ZERO(1'b1)) dut_fast (.clk(clk), .reset(reset), .bus(ifa));
  mdu_ctrl #(.FAST_ZERO(1'b0)) dut_slow (.clk(clk), .reset(reset), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic ez, output logic zero_case);
    longint      sa, sb, sp, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ez = 1'b0;
    zero_case = op[1] ? (b == 0) : (a == 0 || b == 0);
    case (op)
      2'd0: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
      2'd1: begin up = {32'd0, a} * {32'd0, b}; eh = up[63:32]; el = up[31:0]; end
      default: begin
        if (b == 0) begin
          eh = a; el = 32'hFFFF_FFFF; ez = 1'b1;
        end else if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          eh = 32'd0; el = 32'h8000_0000;
        end else if (op == 2'd2) begin
          q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0];
        end else begin
          eh = a % b; el = a / b;
        end
      end
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op = op;
    op1 = a;
    op2 = b;
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic use_slow, input logic flush_in_done);
    logic [31:0] eh, el;
    logic        ez, zc;
    int          lat, k, busy_n;
    sel = use_slow;
    model(op, a, b, eh, el, ez, zc);
    lat = (!use_slow && zc) ? 0 : 32;
    for (int w = 0; w < 40 && o_busy; w++) step();
    issue(op, a, b);
    busy_n = 0;
    for (k = 0; k < 40; k++) begin
      if (o_busy) busy_n++;
      if (o_done) break;
      step();
    end
    chk({tag, ":latency"}, k, lat);
    chk({tag, ":busy_cycles"}, busy_n, lat + 1);
    chk({tag, ":hi"}, o_hi, eh);
    chk({tag, ":lo"}, o_lo, el);
    chk({tag, ":dbz"}, o_dbz, ez);
    if (flush_in_done) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
    end else begin
      step();
    end
    chk({tag, ":done_after"}, o_done, 1'b0);
    chk({tag, ":busy_after"}, o_busy, 1'b0);
    chk({tag, ":hi_hold"}, o_hi, eh);
    chk({tag, ":lo_hold"}, o_lo, el);
  endtask

  initial begin
    int          dones;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    step();
    step();
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      chk("reset:busy", o_busy, 1'b0);
      chk("reset:done", o_done, 1'b0);
      chk("reset:dbz", o_dbz, 1'b0);
      chk("reset:hi", o_hi, 32'd0);
      chk("reset:lo", o_lo, 32'd0);
    end
    reset = 1'b0;
    step();

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("div_wrap", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("divu_7_0_fast", 2'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    run_op("divu_7_0_slow", 2'd3, 32'd7, 32'd0, 1'b1, 1'b0);
    run_op("div_neg_0_fast", 2'd2, 32'hFFFF_FF85, 32'd0, 1'b0, 1'b0);
    run_op("div_neg_0_slow", 2'd2, 32'hFFFF_FF85, 32'd0, 1'b1, 1'b0);
    run_op("mult_zero_fast", 2'd0, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
    run_op("mult_zero_slow", 2'd0, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    run_op("div_m9_m4_slow", 2'd2, 32'hFFFF_FFF7, 32'hFFFF_FFFC, 1'b1, 1'b0);
    run_op("mult_flush_done", 2'd0, 32'h0001_0003, 32'hFFFF_0007, 1'b0, 1'b1);

    // Flush mid-calculation and flush racing a request in IDLE
    run_op("multu_3x4", 2'd1, 32'd3, 32'd4, 1'b0, 1'b0);
    issue(2'd1, 32'd5, 32'd5);
    repeat (10) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush:busy", o_busy, 1'b0);
    chk("flush:done", o_done, 1'b0);
    chk("flush:hi", o_hi, 32'd0);
    chk("flush:lo", o_lo, 32'd12);
    dones = 0;
    for (int c = 0; c < 36; c++) begin
      if (o_done) dones++;
      step();
    end
    chk("flush:no_done", dones, 0);
    req_valid = 1'b1;
    flush = 1'b1;
    req_op = 2'd1;
    op1 = 32'd6;
    op2 = 32'd6;
    step();
    req_valid = 1'b0;
    flush = 1'b0;
    chk("flush_req:busy", o_busy, 1'b0);
    step();
    chk("flush_req:busy2", o_busy, 1'b0);
    chk("flush_req:lo", o_lo, 32'd12);

    // Asynchronous reset in the middle of a divide
    issue(2'd3, 32'd1000, 32'd3);
    repeat (20) step();
    #1 reset = 1'b1;
    #1;
    chk("areset:busy", o_busy, 1'b0);
    chk("areset:done", o_done, 1'b0);
    chk("areset:dbz", o_dbz, 1'b0);
    chk("areset:hi", o_hi, 32'd0);
    chk("areset:lo", o_lo, 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 1'b0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'd0;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op("random", rop, ra, rb, 1'(n % 2), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
